conv2d_pad_stride: RTL and testbench

Second-generation parametric 2D convolution engine for the MNIST inference datapath. It adds zero padding, stride, a configurable fixed-point format and a start/busy/done handshake, so the same instance can be re-run for every image. Output is saturating, and ReLU is selectable. It sits between the input/pooling feature-map buffers and the next conv or dense layer, reading flat arrays and writing a flat output array.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_addr_gen.sv | 44 ++++
 rtl/conv2d_pad_stride.sv | 191 +++++++++++++++++++
 tb/tb_conv2d_pad_stride.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared state encoding, counter type and arithmetic helpers for conv2d_pad_stride.
package conv_pkg;

   localparam int unsigned CNT_W = 16;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      STORE,
      DONE
   } state_t;

   function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k,
                                           input int unsigned pad, input int unsigned stride);
      return (in_dim + 2 * pad - k) / stride + 1;
   endfunction

   // Clamp a wide signed value into the signed range of an out_w-bit word (out_w <= 64).
   function automatic logic signed [63:0] saturate(input logic signed [127:0] v,
                                                   input int unsigned out_w);
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      hi = (128'sd1 <<< (out_w - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      if (v > hi) return hi[63:0];
      if (v < lo) return lo[63:0];
      return v[63:0];
   endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Maps the output-position and tap counters onto flat input/weight indices,
// flagging taps that land in the zero-padding border.
module conv_addr_gen
   import conv_pkg::*;
#(
   parameter int IN_H     = 28,
   parameter int IN_W     = 28,
   parameter int IN_CH    = 1,
   parameter int OUT_CH   = 4,
   parameter int KERNEL_H = 3,
   parameter int KERNEL_W = 3,
   parameter int STRIDE   = 1,
   parameter int PAD      = 0
) (
   input  cnt_t                     orow,
   input  cnt_t                     ocol,
   input  cnt_t                     ch,
   input  cnt_t                     kr,
   input  cnt_t                     kc,
   output logic [31:0]              data_idx,
   output logic [OUT_CH-1:0][31:0]  w_idx,
   output logic                     pad_zero
);

   localparam int TAP = IN_CH * KERNEL_H * KERNEL_W;

   logic signed [31:0] ir;
   logic signed [31:0] ic;
   logic [31:0]        w_tap;

   always_comb begin
      ir       = 32'(int'(orow) * STRIDE + int'(kr) - PAD);
      ic       = 32'(int'(ocol) * STRIDE + int'(kc) - PAD);
      pad_zero = (ir < 0) || (ir >= IN_H) || (ic < 0) || (ic >= IN_W);
      // Out-of-bounds taps are pinned to index 0 so the read stays inside the vector.
      data_idx = pad_zero ? '0 : 32'(int'(ch) * IN_H * IN_W + ir * IN_W + ic);
      w_tap    = 32'(int'(ch) * KERNEL_H * KERNEL_W + int'(kr) * KERNEL_W + int'(kc));
   end

   for (genvar f = 0; f < OUT_CH; f++) begin : g_widx
      assign w_idx[f] = 32'(f * TAP) + w_tap;
   end

endmodule

// File: rtl/conv2d_pad_stride.sv
// Padded, strided 2D convolution: one tap per cycle, one MAC per filter,
// saturating output with optional ReLU and a start/busy/done handshake.
module conv2d_pad_stride
   import conv_pkg::*;
#(
   parameter int IN_H      = 28,
   parameter int IN_W      = 28,
   parameter int IN_CH     = 1,
   parameter int OUT_CH    = 4,
   parameter int KERNEL_H  = 3,
   parameter int KERNEL_W  = 3,
   parameter int STRIDE    = 1,
   parameter int PAD       = 0,
   parameter int DATA_W    = 32,
   parameter int FRAC_BITS = 16,
   parameter int ACC_W     = 56,
   localparam int OUT_H    = int'(out_dim(IN_H, KERNEL_H, PAD, STRIDE)),
   localparam int OUT_W    = int'(out_dim(IN_W, KERNEL_W, PAD, STRIDE))
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          start,
   input  logic                                          activation_function,
   input  logic [DATA_W*IN_CH*IN_H*IN_W-1:0]             data_in,
   input  logic [DATA_W*OUT_CH*IN_CH*KERNEL_H*KERNEL_W-1:0] weights,
   input  logic [DATA_W*OUT_CH-1:0]                      bias,
   output logic                                          busy,
   output logic [DATA_W*OUT_CH*OUT_H*OUT_W-1:0]          data_out,
   output logic                                          done
);

   localparam int NPOS   = OUT_H * OUT_W;
   localparam int X_BITS = DATA_W * IN_CH * IN_H * IN_W;
   localparam int W_BITS = DATA_W * OUT_CH * IN_CH * KERNEL_H * KERNEL_W;
   localparam int O_BITS = DATA_W * NPOS;
   localparam int XB_W   = $clog2(X_BITS);
   localparam int WB_W   = $clog2(W_BITS);
   localparam int OB_W   = $clog2(O_BITS);

   localparam cnt_t LAST_CH   = cnt_t'(IN_CH - 1);
   localparam cnt_t LAST_KR   = cnt_t'(KERNEL_H - 1);
   localparam cnt_t LAST_KC   = cnt_t'(KERNEL_W - 1);
   localparam cnt_t LAST_OCOL = cnt_t'(OUT_W - 1);
   localparam cnt_t LAST_POS  = cnt_t'(NPOS - 1);

   state_t state;
   state_t state_nx;

   cnt_t orow, ocol, ch, kr, kc, pos;
   logic relu;
   logic last_tap, last_pos;
   logic do_clear, do_mac, do_store;

   logic [31:0]             data_idx;
   logic [OUT_CH-1:0][31:0] w_idx;
   logic                    pad_zero;
   logic [XB_W-1:0]         xb;
   logic [OB_W-1:0]         ob;
   logic signed [DATA_W-1:0] x_op;

   conv_addr_gen #(
      .IN_H    (IN_H),
      .IN_W    (IN_W),
      .IN_CH   (IN_CH),
      .OUT_CH  (OUT_CH),
      .KERNEL_H(KERNEL_H),
      .KERNEL_W(KERNEL_W),
      .STRIDE  (STRIDE),
      .PAD     (PAD)
   ) u_addr (
      .orow    (orow),
      .ocol    (ocol),
      .ch      (ch),
      .kr      (kr),
      .kc      (kc),
      .data_idx(data_idx),
      .w_idx   (w_idx),
      .pad_zero(pad_zero)
   );

   assign last_tap = (ch == LAST_CH) && (kr == LAST_KR) && (kc == LAST_KC);
   assign last_pos = (pos == LAST_POS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = COMPUTE;
         COMPUTE: if (last_tap) state_nx = STORE;
         STORE:   state_nx = last_pos ? DONE : COMPUTE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      do_clear = (state == IDLE) && start;
      do_mac   = (state == COMPUTE);
      do_store = (state == STORE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         orow <= '0;
         ocol <= '0;
         ch   <= '0;
         kr   <= '0;
         kc   <= '0;
         pos  <= '0;
         relu <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= (state == DONE);
         if (do_clear) begin
            orow <= '0;
            ocol <= '0;
            ch   <= '0;
            kr   <= '0;
            kc   <= '0;
            pos  <= '0;
            relu <= activation_function;
         end else if (do_mac) begin
            // Tap counters wrap to zero after the last tap, ready for the next position.
            if (kc == LAST_KC) begin
               kc <= '0;
               if (kr == LAST_KR) begin
                  kr <= '0;
                  ch <= (ch == LAST_CH) ? '0 : ch + 1'b1;
               end else begin
                  kr <= kr + 1'b1;
               end
            end else begin
               kc <= kc + 1'b1;
            end
         end else if (do_store) begin
            pos <= pos + 1'b1;
            if (ocol == LAST_OCOL) begin
               ocol <= '0;
               orow <= orow + 1'b1;
            end else begin
               ocol <= ocol + 1'b1;
            end
         end
      end
   end

   always_comb begin
      xb   = XB_W'(data_idx * DATA_W);
      ob   = OB_W'(pos * DATA_W);
      x_op = pad_zero ? '0 : data_in[xb +: DATA_W];
   end

   for (genvar f = 0; f < OUT_CH; f++) begin : g_filt
      logic signed [ACC_W-1:0]    acc;
      logic signed [ACC_W-1:0]    sum;
      logic signed [DATA_W-1:0]   w;
      logic signed [2*DATA_W-1:0] prod;
      logic [WB_W-1:0]            wb;
      logic [O_BITS-1:0]          out_reg;

      always_comb begin
         wb   = WB_W'(w_idx[f] * DATA_W);
         w    = weights[wb +: DATA_W];
         prod = (2*DATA_W)'(w) * (2*DATA_W)'(x_op);
         sum  = acc + ACC_W'($signed(bias[f*DATA_W +: DATA_W]));
         if (relu && sum[ACC_W-1]) sum = '0;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc     <= '0;
            out_reg <= '0;
         end else if (do_clear) begin
            acc <= '0;
         end else if (do_mac) begin
            acc <= acc + ACC_W'(prod >>> FRAC_BITS);
         end else if (do_store) begin
            out_reg[ob +: DATA_W] <= DATA_W'(saturate(128'(sum), DATA_W));
            acc                   <= '0;
         end
      end

      assign data_out[f*O_BITS +: O_BITS] = out_reg;
   end

endmodule

// File: tb/tb_conv2d_pad_stride.sv
// Directed bench for conv2d_pad_stride over four parameterisations; expected
// outputs are queued when a run starts and compared once done pulses.
module tb_conv2d_pad_stride;

   localparam int          DW  = 32;
   localparam logic [31:0] ONE = 32'h0001_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] start;
   logic [3:0] relu;
   logic [3:0] busy;
   logic [3:0] done;

   logic [DW*16-1:0] d0, d1, d2;
   logic [DW*9-1:0]  w0, w1, w2;
   logic [DW-1:0]    b0, b1, b2;
   logic [DW*4-1:0]  o0, o2;
   logic [DW*16-1:0] o1;
   logic [DW*32-1:0] d3;
   logic [DW*36-1:0] w3;
   logic [DW*2-1:0]  b3;
   logic [DW*8-1:0]  o3;

   conv2d_pad_stride #(.IN_H(4), .IN_W(4), .IN_CH(1), .OUT_CH(1), .KERNEL_H(3), .KERNEL_W(3),
      .STRIDE(1), .PAD(0), .DATA_W(32), .FRAC_BITS(16), .ACC_W(56)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .activation_function(relu[0]),
      .data_in(d0), .weights(w0), .bias(b0), .busy(busy[0]), .data_out(o0), .done(done[0]));

   conv2d_pad_stride #(.IN_H(4), .IN_W(4), .IN_CH(1), .OUT_CH(1), .KERNEL_H(3), .KERNEL_W(3),
      .STRIDE(1), .PAD(1), .DATA_W(32), .FRAC_BITS(16), .ACC_W(56)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .activation_function(relu[1]),
      .data_in(d1), .weights(w1), .bias(b1), .busy(busy[1]), .data_out(o1), .done(done[1]));

   conv2d_pad_stride #(.IN_H(4), .IN_W(4), .IN_CH(1), .OUT_CH(1), .KERNEL_H(3), .KERNEL_W(3),
      .STRIDE(2), .PAD(1), .DATA_W(32), .FRAC_BITS(16), .ACC_W(56)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .activation_function(relu[2]),
      .data_in(d2), .weights(w2), .bias(b2), .busy(busy[2]), .data_out(o2), .done(done[2]));

   conv2d_pad_stride #(.IN_H(4), .IN_W(4), .IN_CH(2), .OUT_CH(2), .KERNEL_H(3), .KERNEL_W(3),
      .STRIDE(2), .PAD(1), .DATA_W(32), .FRAC_BITS(16), .ACC_W(56)) u3 (
      .clk(clk), .rst(rst), .start(start[3]), .activation_function(relu[3]),
      .data_in(d3), .weights(w3), .bias(b3), .busy(busy[3]), .data_out(o3), .done(done[3]));

   typedef struct {
      int          inst;
      int          idx;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [31:0] get_out(input int inst, input int idx);
      case (inst)
         0:       return o0[idx*DW +: DW];
         1:       return o1[idx*DW +: DW];
         2:       return o2[idx*DW +: DW];
         default: return o3[idx*DW +: DW];
      endcase
   endfunction

   // Reference for u3: 2 channels, 2 filters, PAD 1, STRIDE 2, 4x4 input.
   function automatic logic [31:0] model3(input int f, input int orow, input int ocol, input logic r);
      longint acc, x, w, s;
      acc = 0;
      for (int ch = 0; ch < 2; ch++)
         for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++) begin
               int ir, ic;
               ir = orow * 2 + kr - 1;
               ic = ocol * 2 + kc - 1;
               if (ir >= 0 && ir < 4 && ic >= 0 && ic < 4) begin
                  x = longint'($signed(d3[(ch*16 + ir*4 + ic)*DW +: DW]));
                  w = longint'($signed(w3[(f*18 + ch*9 + kr*3 + kc)*DW +: DW]));
                  acc += (x * w) >>> 16;
               end
            end
      s = acc + longint'($signed(b3[f*DW +: DW]));
      if (r && s < 0) s = 0;
      if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
      if (s < -64'sh8000_0000) s = -64'sh8000_0000;
      return s[31:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input int inst, input int idx, input logic [31:0] exp);
      sb.push_back('{inst, idx, exp});
   endtask

   // Start a run, optionally re-pulse start while busy, then check latency,
   // busy coverage, queued outputs and the single-cycle done pulse.
   task automatic run(input int inst, input logic r, input int lat, input int poke, input string tag);
      int   n;
      int   busy_low;
      exp_t e;
      @(negedge clk);
      relu[inst]  = r;
      start[inst] = 1'b1;
      @(posedge clk);
      #1 start[inst] = 1'b0;
      n        = 0;
      busy_low = 0;
      while (done[inst] !== 1'b1 && n < 2000) begin
         if (busy[inst] !== 1'b1) busy_low++;
         @(posedge clk);
         #1;
         n++;
         start[inst] = (n == poke);
      end
      start[inst] = 1'b0;
      check({tag, " latency"}, n, lat);
      check({tag, " busy low cycles"}, busy_low, 0);
      check({tag, " busy at done"}, {31'b0, busy[inst]}, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("%s out[%0d]", tag, e.idx), get_out(e.inst, e.idx), e.exp);
      end
      @(posedge clk);
      #1;
      check({tag, " done one cycle"}, {31'b0, done[inst]}, 0);
   endtask

   initial begin
      int n_done;
      rst   = 1'b1;
      start = '0;
      relu  = '0;
      d0 = {16{ONE}};
      w0 = {9{ONE}};
      b0 = '0;
      d1 = d0; w1 = w0; b1 = '0;
      d2 = d0; w2 = w0; b2 = '0;
      d3 = '0; w3 = '0; b3 = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) check($sformatf("reset o0[%0d]", p), get_out(0, p), '0);
      check("reset busy", {28'b0, busy}, '0);
      check("reset done", {28'b0, done}, '0);
      @(negedge clk);
      rst = 1'b0;

      for (int p = 0; p < 4; p++) push(0, p, 32'h0009_0000);
      run(0, 1'b0, 41, -1, "s1");

      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            push(1, r*4 + c, 32'((((r == 0 || r == 3) ? 2 : 3) * ((c == 0 || c == 3) ? 2 : 3)) << 16));
      run(1, 1'b0, 161, -1, "s2 pad");

      push(2, 0, 32'h0004_0000);
      push(2, 1, 32'h0006_0000);
      push(2, 2, 32'h0006_0000);
      push(2, 3, 32'h0009_0000);
      run(2, 1'b0, 41, -1, "s3 stride");

      w0 = {9{32'hFFFF_0000}};
      b0 = 32'h0000_8000;
      for (int p = 0; p < 4; p++) push(0, p, 32'hFFF7_8000);
      run(0, 1'b0, 41, -1, "s4 neg");
      for (int p = 0; p < 4; p++) push(0, p, 32'h0000_0000);
      run(0, 1'b1, 41, -1, "s4 relu");
      d0 = {16{32'h7FFF_0000}};
      for (int p = 0; p < 4; p++) push(0, p, 32'h8000_0000);
      run(0, 1'b0, 41, -1, "s4 sat lo");
      w0 = {9{ONE}};
      for (int p = 0; p < 4; p++) push(0, p, 32'h7FFF_FFFF);
      run(0, 1'b0, 41, -1, "s4 sat hi");
      repeat (5) @(negedge clk);
      check("s4 hold", get_out(0, 3), 32'h7FFF_FFFF);

      d0 = {16{ONE}};
      b0 = '0;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (15) @(negedge clk);
      check("s5 busy mid", {31'b0, busy[0]}, 1);
      rst = 1'b1;
      #2;
      for (int p = 0; p < 4; p++) check($sformatf("s5 rst o0[%0d]", p), get_out(0, p), '0);
      check("s5 rst busy", {31'b0, busy[0]}, 0);
      check("s5 rst done", {31'b0, done[0]}, 0);
      @(negedge clk);
      rst    = 1'b0;
      n_done = 0;
      repeat (60) begin
         @(negedge clk);
         if (done[0] === 1'b1) n_done++;
      end
      check("s5 no done after rst", n_done, 0);
      for (int p = 0; p < 4; p++) push(0, p, 32'h0009_0000);
      run(0, 1'b0, 41, 10, "s5 start while busy");
      for (int p = 0; p < 4; p++) push(0, p, 32'h0009_0000);
      run(0, 1'b0, 41, -1, "s5 rerun");

      for (int i = 0; i < 32; i++) d3[i*DW +: DW] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      for (int i = 0; i < 36; i++) w3[i*DW +: DW] = 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
      for (int i = 0; i < 2; i++)  b3[i*DW +: DW] = 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000;
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) push(3, f*4 + r*2 + c, model3(f, r, c, 1'b0));
      run(3, 1'b0, 77, -1, "s6 multi");
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) push(3, f*4 + r*2 + c, model3(f, r, c, 1'b1));
      run(3, 1'b1, 77, -1, "s6 multi relu");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
